// File: rtl/noc_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_params_pkg
// Description : Shared NoC constants: flit ids, port indices, head field
//               offsets and the XY routing function.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_params_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [1:0] flit_id_t;

    localparam flit_id_t HEAD     = 2'b10;
    localparam flit_id_t BODY     = 2'b00;
    localparam flit_id_t TAIL     = 2'b01;
    localparam flit_id_t HEADTAIL = 2'b11;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Destination column sits at the bottom of the head payload, row right above it.
    localparam int DST_COL_OFS = 0;

    function automatic logic [NUM_PORTS-1:0] xy_route(
        input int dst_row,
        input int dst_col,
        input int row,
        input int col
    );
        logic [NUM_PORTS-1:0] r_oh;
        r_oh = '0;
        if (dst_col > col)      r_oh[EAST]  = 1'b1;
        else if (dst_col < col) r_oh[WEST]  = 1'b1;
        else if (dst_row > row) r_oh[SOUTH] = 1'b1;
        else if (dst_row < row) r_oh[NORTH] = 1'b1;
        else                    r_oh[LOCAL] = 1'b1;
        return r_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flit_fifo
// Description : Synchronous FIFO with combinational front read, full/empty
//               flags and occupancy count. Refuses pushes while full.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int               c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_count == c_full_cnt);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Storage is cleared too so the front word reads zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_unit.sv
`default_nettype none
// ============================================================================
// Module      : input_unit
// Description : Router input port: flit buffer, XY route of head flits and a
//               held one-hot request towards the output allocators.
// Revision    : 1.0 - initial release
// ============================================================================
module input_unit
    import noc_params_pkg::*;
#(
    parameter int FLIT_DATA_W  = 8,
    parameter int FLIT_ID_W    = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int ROW_ADDR_W   = 2,
    parameter int COL_ADDR_W   = 2,
    parameter int ROW_CORD     = 0,
    parameter int COL_CORD     = 0,
    parameter int OUT_N        = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [FLIT_ID_W+FLIT_DATA_W-1:0] data_i,
    input  logic                           wr_en_i,
    output logic                           rdy_o,
    output logic [OUT_N-1:0]               req_o,
    input  logic [OUT_N-1:0]               grant_i,
    input  logic [OUT_N-1:0]               oc_rdy_i,
    output logic [FLIT_ID_W+FLIT_DATA_W-1:0] data_o,
    output logic                           data_vld_o,
    output logic                           is_tail_o,
    output logic                           err_o
);
    localparam int c_flit_w = FLIT_ID_W + FLIT_DATA_W;
    localparam int c_cnt_w  = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(BUFFER_DEPTH);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_routed = 1'b1;

    logic [0:0]            r_state;
    logic [OUT_N-1:0]      r_route_q;
    logic                  w_full;
    logic                  w_empty;
    logic [c_cnt_w-1:0]    w_count;
    logic                  w_push;
    logic                  w_pop;
    logic [FLIT_ID_W-1:0]  w_front_id;
    logic                  w_front_head;
    logic                  w_front_tail;
    logic [COL_ADDR_W-1:0] w_dst_col;
    logic [ROW_ADDR_W-1:0] w_dst_row;
    logic [OUT_N-1:0]      w_route;
    logic                  w_drop;

    flit_fifo #(
        .WIDTH (c_flit_w),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (data_i),
        .data_o  (data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_push       = wr_en_i & ~w_full;
    assign rdy_o        = (w_count != c_full_cnt);
    assign w_front_id   = data_o[FLIT_DATA_W +: FLIT_ID_W];
    assign w_front_head = (w_front_id == HEAD) || (w_front_id == HEADTAIL);
    assign w_front_tail = (w_front_id == TAIL) || (w_front_id == HEADTAIL);
    assign w_dst_col    = data_o[DST_COL_OFS +: COL_ADDR_W];
    assign w_dst_row    = data_o[DST_COL_OFS + COL_ADDR_W +: ROW_ADDR_W];
    assign w_route      = xy_route(int'(w_dst_row), int'(w_dst_col), ROW_CORD, COL_CORD);

    // A stray body/tail at the front of an idle port has no route; discard it.
    assign w_drop     = (r_state == c_st_idle) & ~w_empty & ~w_front_head;
    assign err_o      = w_drop;
    assign is_tail_o  = ~w_empty & w_front_tail;
    assign data_vld_o = (r_state == c_st_routed) & ~w_empty;
    assign req_o      = (r_state == c_st_routed) ? r_route_q : '0;

    always_comb begin
        w_pop = w_drop;
        if (r_state == c_st_routed) begin
            w_pop = (|(grant_i & r_route_q & oc_rdy_i)) & ~w_empty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_st_idle;
            r_route_q <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty && w_front_head) begin
                        r_route_q <= w_route;
                        r_state   <= c_st_routed;
                    end
                end
                c_st_routed: begin
                    if (w_pop && w_front_tail) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_unit
// Description : Directed and randomized checks of input_unit at router (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_unit;
    import noc_params_pkg::*;

    localparam int FW     = 10;
    localparam int NP     = 5;
    localparam int DEPTH  = 4;
    localparam int MY_ROW = 1;
    localparam int MY_COL = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [FW-1:0] data_i;
    logic          wr_en_i;
    logic          rdy_o;
    logic [NP-1:0] req_o;
    logic [NP-1:0] grant_i;
    logic [NP-1:0] oc_rdy_i;
    logic [FW-1:0] data_o;
    logic          data_vld_o;
    logic          is_tail_o;
    logic          err_o;

    input_unit #(
        .FLIT_DATA_W (8), .FLIT_ID_W (2), .BUFFER_DEPTH (DEPTH),
        .ROW_ADDR_W (2), .COL_ADDR_W (2), .ROW_CORD (MY_ROW),
        .COL_CORD (MY_COL), .OUT_N (NP)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .data_i (data_i), .wr_en_i (wr_en_i),
        .rdy_o (rdy_o), .req_o (req_o), .grant_i (grant_i), .oc_rdy_i (oc_rdy_i),
        .data_o (data_o), .data_vld_o (data_vld_o), .is_tail_o (is_tail_o),
        .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of buffered flits plus "which output the current packet owns".
    logic [FW-1:0] m_q [$];
    bit            m_routed;
    int            m_port;
    logic          e_rdy, e_vld, e_tail, e_err;
    logic [NP-1:0] e_req;
    logic [FW-1:0] e_front;
    bit            e_empty;

    function automatic bit id_head(input logic [1:0] id);
        return (id == HEAD) || (id == HEADTAIL);
    endfunction

    function automatic bit id_tail(input logic [1:0] id);
        return (id == TAIL) || (id == HEADTAIL);
    endfunction

    function automatic int ref_route(input logic [FW-1:0] f);
        int dc;
        int dr;
        dc = int'(f[1:0]);
        dr = int'(f[3:2]);
        if (dc > MY_COL) return EAST;
        if (dc < MY_COL) return WEST;
        if (dr > MY_ROW) return SOUTH;
        if (dr < MY_ROW) return NORTH;
        return LOCAL;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_routed = 1'b0;
        m_port   = 0;
    endtask

    task automatic model_eval();
        e_empty = (m_q.size() == 0);
        e_rdy   = (m_q.size() < DEPTH);
        e_front = e_empty ? '0 : m_q[0];
        e_vld   = m_routed && !e_empty;
        e_req   = '0;
        if (m_routed) e_req[m_port] = 1'b1;
        e_tail  = !e_empty && id_tail(e_front[9:8]);
        e_err   = !m_routed && !e_empty && !id_head(e_front[9:8]);
    endtask

    // Drive one cycle's inputs, then settle to mid-cycle and compute expectations.
    task automatic step(input bit wr, input logic [FW-1:0] d,
                        input logic [NP-1:0] g, input logic [NP-1:0] r);
        wr_en_i  = wr;
        data_i   = d;
        grant_i  = g;
        oc_rdy_i = r;
        #4;
        model_eval();
    endtask

    task automatic edge_adv();
        bit            acc;
        bit            popped;
        logic [FW-1:0] f;
        acc    = wr_en_i && (m_q.size() < DEPTH);
        popped = 1'b0;
        if (m_q.size() != 0) begin
            if (m_routed) begin
                popped = grant_i[m_port] && oc_rdy_i[m_port];
            end else if (id_head(m_q[0][9:8])) begin
                m_routed = 1'b1;
                m_port   = ref_route(m_q[0]);
            end else begin
                popped = 1'b1;
            end
        end
        if (popped) begin
            f = m_q.pop_front();
            if (m_routed && id_tail(f[9:8])) m_routed = 1'b0;
        end
        if (acc) m_q.push_back(data_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; wr_en_i = 1'b0; data_i = '0; grant_i = '0; oc_rdy_i = '0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        n_tests++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy_o); end
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL reset_req: got %b want 00000", req_o); end
        n_tests++; if (data_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", data_vld_o); end
        n_tests++; if (is_tail_o !== 1'b0) begin n_fail++; $display("FAIL reset_tail: got %b want 0", is_tail_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_tests++; if (data_o !== 10'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000", data_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_packet_east();
        logic [NP-1:0] g = 5'b00100;
        logic [NP-1:0] r = 5'b11111;
        step(1, {HEAD, 8'h07}, g, r);
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL east_req_t0: got %b want 00000", req_o); end
        edge_adv();
        step(1, {BODY, 8'hA5}, g, r);
        n_tests++; if (data_o !== {HEAD, 8'h07}) begin n_fail++; $display("FAIL east_data_t1: got %h want %h", data_o, {HEAD, 8'h07}); end
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL east_req_t1: got %b want 00000", req_o); end
        edge_adv();
        step(1, {TAIL, 8'h3C}, g, r);
        n_tests++; if (req_o !== 5'b00100) begin n_fail++; $display("FAIL east_req_t2: got %b want 00100", req_o); end
        n_tests++; if (data_vld_o !== 1'b1) begin n_fail++; $display("FAIL east_vld_t2: got %b want 1", data_vld_o); end
        edge_adv();
        step(0, '0, g, r);
        n_tests++; if (data_o !== {BODY, 8'hA5} || is_tail_o !== 1'b0) begin n_fail++; $display("FAIL east_body: got %h/%b want %h/0", data_o, is_tail_o, {BODY, 8'hA5}); end
        edge_adv();
        step(0, '0, g, r);
        n_tests++; if (data_o !== {TAIL, 8'h3C} || is_tail_o !== 1'b1) begin n_fail++; $display("FAIL east_tail: got %h/%b want %h/1", data_o, is_tail_o, {TAIL, 8'h3C}); end
        edge_adv();
        step(0, '0, g, r);
        n_tests++; if (req_o !== 5'b0 || data_vld_o !== 1'b0) begin n_fail++; $display("FAIL east_done: got req %b vld %b want 00000 0", req_o, data_vld_o); end
        edge_adv();
    endtask

    task automatic test_local();
        logic [NP-1:0] g = 5'b00001;
        step(1, {HEADTAIL, 8'h05}, g, 5'b11111);
        edge_adv();
        step(0, '0, g, 5'b11111);
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL local_req_t1: got %b want 00000", req_o); end
        edge_adv();
        step(0, '0, g, 5'b11111);
        n_tests++; if (req_o !== 5'b00001 || is_tail_o !== 1'b1) begin n_fail++; $display("FAIL local_req: got %b/%b want 00001/1", req_o, is_tail_o); end
        edge_adv();
        step(0, '0, g, 5'b11111);
        n_tests++; if (req_o !== 5'b0 || data_vld_o !== 1'b0) begin n_fail++; $display("FAIL local_idle: got req %b vld %b want 00000 0", req_o, data_vld_o); end
        edge_adv();
    endtask

    task automatic test_routes();
        step(1, {HEAD, 8'h01}, 5'b0, 5'b11111);
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        edge_adv();
        step(0, '0, 5'b11101, 5'b11111);
        n_tests++; if (req_o !== 5'b00010) begin n_fail++; $display("FAIL north_req: got %b want 00010", req_o); end
        edge_adv();
        step(0, '0, 5'b00010, 5'b11101);
        n_tests++; if (data_o !== {HEAD, 8'h01} || data_vld_o !== 1'b1) begin n_fail++; $display("FAIL north_hold: got %h/%b want %h/1", data_o, data_vld_o, {HEAD, 8'h01}); end
        edge_adv();
        step(0, '0, 5'b00010, 5'b11111);
        n_tests++; if (data_o !== {HEAD, 8'h01}) begin n_fail++; $display("FAIL north_nopop: got %h want %h", data_o, {HEAD, 8'h01}); end
        edge_adv();
        step(1, {TAIL, 8'h11}, 5'b00010, 5'b11111);
        n_tests++; if (req_o !== 5'b00010 || data_vld_o !== 1'b0) begin n_fail++; $display("FAIL north_empty: got req %b vld %b want 00010 0", req_o, data_vld_o); end
        edge_adv();
        step(0, '0, 5'b00010, 5'b11111);
        n_tests++; if (is_tail_o !== 1'b1 || data_vld_o !== 1'b1) begin n_fail++; $display("FAIL north_tail: got tail %b vld %b want 1 1", is_tail_o, data_vld_o); end
        edge_adv();
        step(0, '0, 5'b10000, 5'b11111);
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL north_done: got %b want 00000", req_o); end
        edge_adv();
        step(1, {HEADTAIL, 8'h0C}, 5'b10000, 5'b11111);
        edge_adv();
        step(0, '0, 5'b10000, 5'b11111);
        edge_adv();
        step(0, '0, 5'b10000, 5'b11111);
        n_tests++; if (req_o !== 5'b10000) begin n_fail++; $display("FAIL west_req: got %b want 10000", req_o); end
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL west_done: got %b want 00000", req_o); end
        edge_adv();
    endtask

    task automatic test_err();
        step(1, {BODY, 8'h42}, 5'b0, 5'b11111);
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", err_o); end
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (err_o !== 1'b1 || req_o !== 5'b0) begin n_fail++; $display("FAIL err_pulse: got err %b req %b want 1 00000", err_o, req_o); end
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (err_o !== 1'b0 || req_o !== 5'b0 || data_vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("FAIL err_after: got err %b req %b vld %b rdy %b want 0 00000 0 1", err_o, req_o, data_vld_o, rdy_o); end
        edge_adv();
    endtask

    task automatic test_full();
        step(1, {HEAD, 8'h07}, 5'b0, 5'b11111); edge_adv();
        for (int i = 1; i <= 3; i++) begin
            step(1, {BODY, 8'(i)}, 5'b0, 5'b11111);
            n_tests++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL full_rdy_%0d: got %b want 1", i, rdy_o); end
            edge_adv();
        end
        step(1, {TAIL, 8'hEE}, 5'b0, 5'b11111);
        n_tests++; if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL full_rdy4: got %b want 0", rdy_o); end
        edge_adv();
        step(1, {TAIL, 8'hEE}, 5'b00100, 5'b11111);
        n_tests++; if (rdy_o !== 1'b0 || data_vld_o !== 1'b1) begin n_fail++; $display("FAIL full_poppush: got rdy %b vld %b want 0 1", rdy_o, data_vld_o); end
        edge_adv();
        step(0, '0, 5'b00100, 5'b11111);
        n_tests++; if (rdy_o !== 1'b1 || data_o !== {BODY, 8'h01}) begin n_fail++; $display("FAIL full_after: got rdy %b data %h want 1 %h", rdy_o, data_o, {BODY, 8'h01}); end
        edge_adv();
        step(0, '0, 5'b00100, 5'b11111); edge_adv();
        step(0, '0, 5'b00100, 5'b11111);
        n_tests++; if (data_o !== {BODY, 8'h03}) begin n_fail++; $display("FAIL full_last: got %h want %h", data_o, {BODY, 8'h03}); end
        edge_adv();
        step(1, {TAIL, 8'h77}, 5'b00100, 5'b11111);
        n_tests++; if (data_vld_o !== 1'b0 || req_o !== 5'b00100) begin n_fail++; $display("FAIL full_refused: got vld %b req %b want 0 00100", data_vld_o, req_o); end
        edge_adv();
        step(0, '0, 5'b00100, 5'b11111);
        n_tests++; if (data_o !== {TAIL, 8'h77} || is_tail_o !== 1'b1) begin n_fail++; $display("FAIL full_tail: got %h/%b want %h/1", data_o, is_tail_o, {TAIL, 8'h77}); end
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (req_o !== 5'b0 || data_vld_o !== 1'b0) begin n_fail++; $display("FAIL full_done: got req %b vld %b want 00000 0", req_o, data_vld_o); end
        edge_adv();
    endtask

    task automatic test_reset_mid();
        step(1, {HEAD, 8'h07}, 5'b0, 5'b11111); edge_adv();
        step(1, {BODY, 8'h01}, 5'b0, 5'b11111); edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (data_vld_o !== 1'b1 || req_o !== 5'b00100) begin n_fail++; $display("FAIL mid_pre: got vld %b req %b want 1 00100", data_vld_o, req_o); end
        rst_ni = 1'b0;
        #1;
        n_tests++; if (req_o !== 5'b0 || data_vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got req %b vld %b rdy %b want 00000 0 1", req_o, data_vld_o, rdy_o); end
        model_clear();
        wr_en_i = 1'b0; grant_i = '0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1, {HEADTAIL, 8'h0C}, 5'b10000, 5'b11111); edge_adv();
        step(0, '0, 5'b10000, 5'b11111); edge_adv();
        step(0, '0, 5'b10000, 5'b11111);
        n_tests++; if (req_o !== 5'b10000 || data_o !== {HEADTAIL, 8'h0C}) begin n_fail++; $display("FAIL mid_route: got req %b data %h want 10000 %h", req_o, data_o, {HEADTAIL, 8'h0C}); end
        edge_adv();
        step(0, '0, 5'b0, 5'b11111);
        n_tests++; if (req_o !== 5'b0) begin n_fail++; $display("FAIL mid_done: got %b want 00000", req_o); end
        edge_adv();
    endtask

    task automatic test_random();
        logic [FW-1:0] d;
        for (int c = 0; c < 600; c++) begin
            d = {2'($urandom_range(0, 3)), 8'($urandom)};
            step(($urandom_range(0, 9) < 6), d, 5'($urandom), 5'($urandom));
            n_tests++; if (rdy_o !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy@%0d: got %b want %b", c, rdy_o, e_rdy); end
            n_tests++; if (req_o !== e_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", c, req_o, e_req); end
            n_tests++; if (data_vld_o !== e_vld) begin n_fail++; $display("FAIL rnd_vld@%0d: got %b want %b", c, data_vld_o, e_vld); end
            n_tests++; if (err_o !== e_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", c, err_o, e_err); end
            n_tests++; if (is_tail_o !== e_tail) begin n_fail++; $display("FAIL rnd_tail@%0d: got %b want %b", c, is_tail_o, e_tail); end
            if (!e_empty) begin
                n_tests++; if (data_o !== e_front) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, data_o, e_front); end
            end
            edge_adv();
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk_i);
        #1;
        test_packet_east();
        test_local();
        test_routes();
        test_err();
        test_full();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_unit.md
Name: input_unit

Overview:
- Per-input-port stage of the router that sits directly upstream of the per-output allocators and the crossbar.
- Buffers incoming flits in a small FIFO and computes an XY route for each head flit.
- Holds a one-hot request towards the selected output allocator until that packet's tail flit leaves.
- Presents the front flit, its valid bit and its tail flag to the allocator and crossbar, and pops on grant plus downstream ready.

Parameters:
- FLIT_DATA_W, 8, payload width; the head payload carries the destination.
- FLIT_ID_W, 2, flit type field width.
- BUFFER_DEPTH, 4, FIFO depth in flits; power of two, ≥2.
- ROW_ADDR_W, 2, row coordinate width.
- COL_ADDR_W, 2, column coordinate width.
- ROW_CORD, 0, this router's row.
- COL_CORD, 0, this router's column.
- OUT_N, 5, number of output ports.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  FLIT_ID_W+FLIT_DATA_W  incoming flit, {id, payload}.
- wr_en_i  in  1  upstream flit valid.
- rdy_o  out  1  buffer can accept a flit (not full).
- req_o  out  OUT_N  one-hot request, bit k goes to output k allocator req_i.
- grant_i  in  OUT_N  bit k from output k allocator grant_o.
- oc_rdy_i  in  OUT_N  per-output forward-node ready.
- data_o  out  FLIT_ID_W+FLIT_DATA_W  FIFO front flit, to the crossbar.
- data_vld_o  out  1  front flit valid (FIFO not empty and state ROUTED).
- is_tail_o  out  1  front flit id is TAIL or HEADTAIL.
- err_o  out  1  one-cycle pulse when a non-head flit is dropped in IDLE.

Behaviour:
- Reset (async, any time including mid-packet):
  - FIFO emptied, pointers and count set to 0, state IDLE, route_q=0.
  - Outputs: rdy_o=1, req_o=0, data_vld_o=0, is_tail_o=0, err_o=0, data_o=0.
- Flit ids (package constants): HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
- Head payload fields: dst_col = payload[COL_ADDR_W-1:0], dst_row = payload[COL_ADDR_W +: ROW_ADDR_W].
- FIFO:
  - Write occurs when wr_en_i & rdy_o.
  - rdy_o = (count != BUFFER_DEPTH). When full, a write is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo BUFFER_DEPTH.
  - data_o = mem[rd_ptr], combinational.
  - A flit written in cycle t is visible on data_o in cycle t+1.
- XY route (combinational on the front head flit):
  - dst_col > COL_CORD → EAST(2).
  - dst_col < COL_CORD → WEST(4).
  - else dst_row > ROW_CORD → SOUTH(3).
  - else dst_row < ROW_CORD → NORTH(1).
  - else LOCAL(0).
  - Result is one-hot, OUT_N bits.
- FSM IDLE:
  - If FIFO not empty and front id is HEAD or HEADTAIL: route_q ← route, go ROUTED. No pop.
  - If FIFO not empty and front id is BODY or TAIL: pop and discard, err_o=1 for one cycle, stay IDLE.
  - req_o=0 in IDLE.
- FSM ROUTED:
  - req_o = route_q.
  - Pop condition: pop = |(grant_i & route_q & oc_rdy_i) & ~empty.
  - On popping a flit with is_tail_o=1, go IDLE; req_o=0 from the next cycle.
  - While ROUTED with FIFO empty, req_o stays asserted and data_vld_o=0.
- Latency: head written at t → on data_o at t+1 → req_o at t+2 → earliest pop at t+3, given the allocator's registered grant.
- Back-to-back packets: after a tail pop, a next head at the front goes ROUTED one cycle later. There is always at least one idle-request cycle between packets.
- grant_i bits outside route_q are ignored.

Decomposition:
- Package noc_params_pkg holds:
  - flit id constants.
  - port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - flit field offsets.
  - function xy_route(dst_row, dst_col, row, col), returning the OUT_N one-hot route.
- One sub-module, flit_fifo: synchronous FIFO with parameterised width and depth, providing full, empty and count.
- FSM and route register live in input_unit.

Test Plan:
- Router (1,1); HEAD dst (row1,col3), BODY, TAIL written back-to-back; grant_i=00100 held with oc_rdy_i=11111 → req_o=00100 at t+2; three pops on consecutive cycles; is_tail_o=1 on the third; req_o=0 the cycle after.
- Router (1,1); HEADTAIL dst (1,1) → req_o=00001 (LOCAL); single pop; returns to IDLE.
- Router (1,1); HEAD dst col1 row0 → NORTH 00010. HEAD dst col0 → WEST 10000, with row ignored.
- BODY flit written while IDLE → popped, err_o=1 for exactly one cycle, req_o stays 0.
- 4 writes with no grant → rdy_o=0 after the 4th; 5th write refused; a write in the same cycle as a pop while full is refused; after the pop, rdy_o=1.
- Reset asserted mid-packet with FIFO holding 2 flits → immediately req_o=0, data_vld_o=0, rdy_o=1; a new HEAD after release routes normally.
